// File: rtl/host_seq_pkg.sv
// host_seq_pkg: shared state encoding and default widths for the host step
// sequencer and its ready/valid bridge.
//   host_seq_state_e : 3-bit sequencer state
//   *_W_DEF          : default parameter widths
//   seq_busy()       : true for the states that own a bridge
package host_seq_pkg;

  localparam int unsigned INSN_W_DEF = 32;
  localparam int unsigned IO_W_DEF   = 16;
  localparam int unsigned CNT_W_DEF  = 16;
  localparam int unsigned WDOG_W_DEF = 16;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LOAD   = 3'd1,
    S_STEP_I = 3'd2,
    S_STEP_O = 3'd3,
    S_DONE   = 3'd4,
    S_ERROR  = 3'd5
  } host_seq_state_e;

  function automatic logic seq_busy(host_seq_state_e s);
    return (s == S_LOAD) || (s == S_STEP_I) || (s == S_STEP_O);
  endfunction

endpackage

// File: rtl/hs_bridge.sv
// hs_bridge: gated combinational ready/valid pass-through.
// When en_i is low both handshake directions and the data are forced to 0,
// so an idle bridge never accepts or offers a word.
//   en_i                         : bridge enable
//   s_valid_i/s_ready_o/s_bits_i : upstream (source) side
//   m_valid_o/m_ready_i/m_bits_o : downstream (sink) side
//   fire_o                       : a word transfers this cycle
module hs_bridge #(
  parameter int unsigned W = 16
) (
  input  logic         en_i,
  input  logic         s_valid_i,
  output logic         s_ready_o,
  input  logic [W-1:0] s_bits_i,
  output logic         m_valid_o,
  input  logic         m_ready_i,
  output logic [W-1:0] m_bits_o,
  output logic         fire_o
);

  assign m_valid_o = en_i & s_valid_i;
  assign s_ready_o = en_i & m_ready_i;
  assign m_bits_o  = en_i ? s_bits_i : '0;
  assign fire_o    = en_i & s_valid_i & m_ready_i;

endmodule

// File: rtl/host_step_sequencer.sv
// host_step_sequencer: forwards num_insns instruction words into the emulator,
// then runs host_steps steps of (one io_i word in, one io_o word out).
// Ports: clock/reset (sync, active-high); start/abort control; num_insns,
// host_steps, timeout_limit config; src_insn, src_io, dst_io host streams;
// dut_insns, dut_io_i, dut_io_o emulator streams; busy/done/error/steps_done.
// Optional build macro HOST_SEQ_WATCHDOG_EN adds a stall watchdog that sends
// a stuck step to ERROR; without it timeout_limit is ignored and error is 0.
//
// state    | meaning
// IDLE     | waiting for start
// LOAD     | forwarding instruction words
// STEP_I   | waiting for one io_i word to reach the emulator
// STEP_O   | waiting for one io_o word to reach the host
// DONE     | run complete, holds until start/abort/reset
// ERROR    | watchdog timeout, holds until start/abort/reset
module host_step_sequencer
  import host_seq_pkg::*;
#(
  parameter int unsigned INSN_W = INSN_W_DEF,
  parameter int unsigned IO_W   = IO_W_DEF,
  parameter int unsigned CNT_W  = CNT_W_DEF,
  parameter int unsigned WDOG_W = WDOG_W_DEF
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              start,
  input  logic              abort,
  input  logic [CNT_W-1:0]  num_insns,
  input  logic [CNT_W-1:0]  host_steps,
  input  logic [WDOG_W-1:0] timeout_limit,
  input  logic              src_insn_valid,
  output logic              src_insn_ready,
  input  logic [INSN_W-1:0] src_insn_bits,
  input  logic              src_io_valid,
  output logic              src_io_ready,
  input  logic [IO_W-1:0]   src_io_bits,
  output logic              dst_io_valid,
  input  logic              dst_io_ready,
  output logic [IO_W-1:0]   dst_io_bits,
  output logic              dut_insns_valid,
  input  logic              dut_insns_ready,
  output logic [INSN_W-1:0] dut_insns_bits,
  output logic              dut_io_i_valid,
  input  logic              dut_io_i_ready,
  output logic [IO_W-1:0]   dut_io_i_bits,
  input  logic              dut_io_o_valid,
  output logic              dut_io_o_ready,
  input  logic [IO_W-1:0]   dut_io_o_bits,
  output logic              busy,
  output logic              done,
  output logic              error,
  output logic [CNT_W-1:0]  steps_done
);

  host_seq_state_e state_q, state_d;
  logic [CNT_W-1:0] insn_left_q, insn_left_d;
  logic [CNT_W-1:0] step_left_q, step_left_d;
  logic [CNT_W-1:0] steps_done_q, steps_done_d;
  logic insn_fire, io_i_fire, io_o_fire;

  hs_bridge #(.W(INSN_W)) u_insn_bridge (
    .en_i(state_q == S_LOAD),
    .s_valid_i(src_insn_valid), .s_ready_o(src_insn_ready), .s_bits_i(src_insn_bits),
    .m_valid_o(dut_insns_valid), .m_ready_i(dut_insns_ready), .m_bits_o(dut_insns_bits),
    .fire_o(insn_fire)
  );

  hs_bridge #(.W(IO_W)) u_io_i_bridge (
    .en_i(state_q == S_STEP_I),
    .s_valid_i(src_io_valid), .s_ready_o(src_io_ready), .s_bits_i(src_io_bits),
    .m_valid_o(dut_io_i_valid), .m_ready_i(dut_io_i_ready), .m_bits_o(dut_io_i_bits),
    .fire_o(io_i_fire)
  );

  hs_bridge #(.W(IO_W)) u_io_o_bridge (
    .en_i(state_q == S_STEP_O),
    .s_valid_i(dut_io_o_valid), .s_ready_o(dut_io_o_ready), .s_bits_i(dut_io_o_bits),
    .m_valid_o(dst_io_valid), .m_ready_i(dst_io_ready), .m_bits_o(dst_io_bits),
    .fire_o(io_o_fire)
  );

`ifdef HOST_SEQ_WATCHDOG_EN
  logic [WDOG_W-1:0] wdog_q, wdog_d;
  logic [WDOG_W-1:0] wdog_inc;
  host_seq_state_e   stall_state_q, stall_state_d;
`else
  logic unused_timeout_limit;
  assign unused_timeout_limit = ^timeout_limit;
`endif

  always_comb begin
    state_d      = state_q;
    insn_left_d  = insn_left_q;
    step_left_d  = step_left_q;
    steps_done_d = steps_done_q;

    // Abort wins over start and over any fire: counters stay frozen.
    if (abort) begin
      state_d = S_IDLE;
    end else begin
      unique case (state_q)
        S_IDLE, S_DONE, S_ERROR: begin
          if (start) begin
            insn_left_d  = num_insns;
            step_left_d  = host_steps;
            steps_done_d = '0;
            if (num_insns != '0)       state_d = S_LOAD;
            else if (host_steps != '0) state_d = S_STEP_I;
            else                       state_d = S_DONE;
          end
        end
        S_LOAD: begin
          if (insn_fire) begin
            if (insn_left_q != '0) insn_left_d = insn_left_q - CNT_W'(1);
            if (insn_left_q == CNT_W'(1))
              state_d = (step_left_q == '0) ? S_DONE : S_STEP_I;
          end
        end
        S_STEP_I: begin
          if (io_i_fire) state_d = S_STEP_O;
        end
        S_STEP_O: begin
          if (io_o_fire) begin
            if (step_left_q != '0) step_left_d = step_left_q - CNT_W'(1);
            if (steps_done_q != '1) steps_done_d = steps_done_q + CNT_W'(1);
            // <= 1 rather than == 1 so a zero count can never spin forever.
            state_d = (step_left_q <= CNT_W'(1)) ? S_DONE : S_STEP_I;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end

`ifdef HOST_SEQ_WATCHDOG_EN
    // The counter value compared is the one this cycle would produce, so
    // ERROR is visible exactly timeout_limit cycles after the stall began.
    stall_state_d = stall_state_q;
    wdog_inc      = wdog_q + WDOG_W'(1);
    if (!abort && (state_q == S_STEP_I || state_q == S_STEP_O) &&
        !io_i_fire && !io_o_fire &&
        timeout_limit != '0 && wdog_inc == timeout_limit) begin
      state_d       = S_ERROR;
      stall_state_d = state_q;
    end
    if (state_d != state_q || insn_fire || io_i_fire || io_o_fire)
      wdog_d = '0;
    else if (state_q == S_STEP_I || state_q == S_STEP_O)
      wdog_d = wdog_inc;
    else
      wdog_d = '0;
`endif
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q      <= S_IDLE;
      insn_left_q  <= '0;
      step_left_q  <= '0;
      steps_done_q <= '0;
`ifdef HOST_SEQ_WATCHDOG_EN
      wdog_q        <= '0;
      stall_state_q <= S_IDLE;
`endif
    end else begin
      state_q      <= state_d;
      insn_left_q  <= insn_left_d;
      step_left_q  <= step_left_d;
      steps_done_q <= steps_done_d;
`ifdef HOST_SEQ_WATCHDOG_EN
      wdog_q        <= wdog_d;
      stall_state_q <= stall_state_d;
`endif
    end
  end

  assign busy       = seq_busy(state_q);
  assign done       = (state_q == S_DONE);
  assign steps_done = steps_done_q;
`ifdef HOST_SEQ_WATCHDOG_EN
  assign error = (state_q == S_ERROR);
`else
  assign error = 1'b0;
`endif

endmodule

// File: tb/tb_host_step_sequencer.sv
// Directed self-checking bench for host_step_sequencer (default widths).
// Expected values are hand-derived cycle positions and data patterns.
// The watchdog step adapts its expectations to HOST_SEQ_WATCHDOG_EN.
`define CHK(tag, obs, exp) \
  begin \
    n_cmp++; \
    assert ((obs) === (exp)) else begin \
      n_err++; \
      $error("FAIL %s: observed %0h expected %0h", tag, (obs), (exp)); \
    end \
  end

module tb_host_step_sequencer;

  logic        clock = 1'b0;
  logic        reset, start, abort;
  logic [15:0] num_insns, host_steps, timeout_limit;
  logic        src_insn_valid, src_insn_ready;
  logic [31:0] src_insn_bits;
  logic        src_io_valid, src_io_ready;
  logic [15:0] src_io_bits;
  logic        dst_io_valid, dst_io_ready;
  logic [15:0] dst_io_bits;
  logic        dut_insns_valid, dut_insns_ready;
  logic [31:0] dut_insns_bits;
  logic        dut_io_i_valid, dut_io_i_ready;
  logic [15:0] dut_io_i_bits;
  logic        dut_io_o_valid, dut_io_o_ready;
  logic [15:0] dut_io_o_bits;
  logic        busy, done, error;
  logic [15:0] steps_done;

  int n_cmp = 0;
  int n_err = 0;
  int cyc, ios, outs, stall_bad;
  logic [5:0] hs;
  logic       wd_on;

  assign hs = {src_insn_ready, src_io_ready, dst_io_valid,
               dut_insns_valid, dut_io_i_valid, dut_io_o_ready};

  always #5 clock = ~clock;

  host_step_sequencer dut (
    .clock(clock), .reset(reset), .start(start), .abort(abort),
    .num_insns(num_insns), .host_steps(host_steps), .timeout_limit(timeout_limit),
    .src_insn_valid(src_insn_valid), .src_insn_ready(src_insn_ready), .src_insn_bits(src_insn_bits),
    .src_io_valid(src_io_valid), .src_io_ready(src_io_ready), .src_io_bits(src_io_bits),
    .dst_io_valid(dst_io_valid), .dst_io_ready(dst_io_ready), .dst_io_bits(dst_io_bits),
    .dut_insns_valid(dut_insns_valid), .dut_insns_ready(dut_insns_ready), .dut_insns_bits(dut_insns_bits),
    .dut_io_i_valid(dut_io_i_valid), .dut_io_i_ready(dut_io_i_ready), .dut_io_i_bits(dut_io_i_bits),
    .dut_io_o_valid(dut_io_o_valid), .dut_io_o_ready(dut_io_o_ready), .dut_io_o_bits(dut_io_o_bits),
    .busy(busy), .done(done), .error(error), .steps_done(steps_done)
  );

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Start pulse in the current cycle (cycle 0); returns in cycle 1.
  task automatic launch(input logic [15:0] ni, input logic [15:0] hsteps);
    num_insns  = ni;
    host_steps = hsteps;
    start      = 1'b1;
    tick();
    start      = 1'b0;
  endtask

  // Cycle index (relative to the start cycle) at which done is first seen.
  task automatic wait_done(input int first_cyc, output int at);
    at = first_cyc;
    while (!done && at < 300) begin
      tick();
      at++;
    end
  endtask

  initial begin
`ifdef HOST_SEQ_WATCHDOG_EN
    wd_on = 1'b1;
`else
    wd_on = 1'b0;
`endif
    reset = 1'b1; start = 1'b0; abort = 1'b0;
    num_insns = '0; host_steps = '0; timeout_limit = '0;
    src_insn_valid = 1'b1; src_insn_bits = 32'hDEAD_BEEF;
    src_io_valid = 1'b1;   src_io_bits = 16'h1234;
    dst_io_ready = 1'b1;
    dut_insns_ready = 1'b1; dut_io_i_ready = 1'b1;
    dut_io_o_valid = 1'b1;  dut_io_o_bits = 16'h4321;

    // Reset state: all peers active, sequencer must stay silent.
    tick(); tick();
    `CHK("rst_hs", hs, 6'b0)
    `CHK("rst_flags", {busy, done, error}, 3'b000)
    `CHK("rst_steps", steps_done, 16'd0)
    `CHK("rst_bits", {dut_insns_bits, dut_io_i_bits, dst_io_bits}, 64'd0)
    reset = 1'b0;
    tick();

    // 4 insns, 3 steps, all peers ready; a stray start mid-run is ignored.
    num_insns = 16'd4; host_steps = 16'd3; start = 1'b1;
    tick();
    start = 1'b0;
    for (cyc = 1; cyc <= 10; cyc++) begin
      src_insn_bits = 32'hC0DE_0000 | cyc;
      src_io_bits   = 16'h5A00 | 16'(cyc);
      dut_io_o_bits = 16'hA500 | 16'(cyc);
      if (cyc == 5) begin
        start = 1'b1; num_insns = 16'd0; host_steps = 16'd0;
      end else begin
        start = 1'b0;
      end
      #1;
      if (cyc <= 4) begin
        `CHK("t1_hs_load", hs, 6'b100100)
        `CHK("t1_insn_bits", dut_insns_bits, 32'hC0DE_0000 | cyc)
      end else if (cyc[0]) begin
        `CHK("t1_hs_stepi", hs, 6'b010010)
        `CHK("t1_io_i_bits", dut_io_i_bits, 16'h5A00 | 16'(cyc))
      end else begin
        `CHK("t1_hs_stepo", hs, 6'b001001)
        `CHK("t1_dst_bits", dst_io_bits, 16'hA500 | 16'(cyc))
      end
      `CHK("t1_busy", {busy, done}, 2'b10)
      tick();
    end
    start = 1'b0;
    `CHK("t1_done_c11", {busy, done}, 2'b01)
    `CHK("t1_steps", steps_done, 16'd3)
    tick();
    `CHK("t1_done_hold", done, 1'b1)

    // 0 insns, 0 steps: DONE one cycle later, no bridge activity.
    num_insns = 16'd0; host_steps = 16'd0; start = 1'b1;
    #1;
    `CHK("t2_hs_c0", hs, 6'b0)
    tick();
    start = 1'b0;
    `CHK("t2_hs_c1", hs, 6'b0)
    `CHK("t2_done", done, 1'b1)
    `CHK("t2_steps", steps_done, 16'd0)

    // 5 steps, io_o stalled 50 cycles during step 2.
    launch(16'd0, 16'd5);
    cyc = 1; ios = 0; outs = 0; stall_bad = 0;
    while (!done && cyc < 200) begin
      dut_io_o_valid = !(cyc >= 4 && cyc < 54);
      #1;
      if (src_io_valid && src_io_ready) ios++;
      if (dst_io_valid && dst_io_ready) outs++;
      if (cyc >= 4 && cyc < 54 && (src_io_ready || dst_io_valid || steps_done != 16'd1 || !busy))
        stall_bad++;
      tick();
      cyc++;
    end
    dut_io_o_valid = 1'b1;
    `CHK("t3_stall_bad", stall_bad, 0)
    `CHK("t3_done_cyc", cyc, 61)
    `CHK("t3_ios", ios, 5)
    `CHK("t3_outs", outs, 5)
    `CHK("t3_steps", steps_done, 16'd5)

    // Abort coinciding with the 2nd instruction fire.
    launch(16'd8, 16'd2);
    `CHK("t4_c1_load", dut_insns_valid, 1'b1)
    tick();
    abort = 1'b1;
    #1;
    `CHK("t4_abort_fire", {dut_insns_valid, src_insn_ready}, 2'b11)
    tick();
    abort = 1'b0;
    `CHK("t4_idle_hs", hs, 6'b0)
    `CHK("t4_flags", {busy, done, error}, 3'b000)
    `CHK("t4_steps", steps_done, 16'd0)

    // Watchdog: io_i never ready.
    timeout_limit = 16'd20;
    dut_io_i_ready = 1'b0;
    launch(16'd1, 16'd1);
    tick();
    `CHK("t5_stepi", dut_io_i_valid, 1'b1)
    repeat (19) tick();
    `CHK("t5_c21_err", error, 1'b0)
    tick();
    `CHK("t5_c22_err", error, wd_on)
    `CHK("t5_c22_busy", busy, !wd_on)
    tick();
    `CHK("t5_err_hold", error, wd_on)
    dut_io_i_ready = 1'b1;
    if (!wd_on) begin
      abort = 1'b1;
      tick();
      abort = 1'b0;
    end
    launch(16'd0, 16'd1);
    `CHK("t5_restart_err", {error, busy}, 2'b01)
    wait_done(1, cyc);
    `CHK("t5_restart_done", cyc, 3)
    timeout_limit = 16'd0;

    // Reset pulsed in STEP_O, then a fresh run.
    launch(16'd0, 16'd2);
    tick();
    reset = 1'b1;
    #1;
    `CHK("t6_in_stepo", dst_io_valid, 1'b1)
    tick();
    reset = 1'b0;
    `CHK("t6_hs", hs, 6'b0)
    `CHK("t6_flags", {busy, done, error}, 3'b000)
    `CHK("t6_steps", steps_done, 16'd0)
    `CHK("t6_bits", {dut_insns_bits, dut_io_i_bits, dst_io_bits}, 64'd0)
    launch(16'd2, 16'd2);
    wait_done(1, cyc);
    `CHK("t6_run_cyc", cyc, 7)
    `CHK("t6_run_steps", steps_done, 16'd2)

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
